// File: rtl/sub8u_approx_pipe.sv
// sub8u_approx_pipe: two-stage valid/ready pipelined 8-bit approximate subtractor.
// The low APPROX_BITS result bits are copied from A, and the borrow out of that
// field is dropped. The upper field is an exact 9-K bit subtraction.
// Optional error statistics are built when the macro APPROX_ERRMON_EN is defined.
// Without it, err_max/err_sum/err_cnt read as zero and stat_clr is ignored.
module sub8u_approx_pipe #(
  parameter int unsigned APPROX_BITS = 4,
  parameter int unsigned SUM_W       = 24,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8:0]       out_d,
  input  logic             stat_clr,
  output logic [8:0]       err_max,
  output logic [SUM_W-1:0] err_sum,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned DW = 8;
  localparam int unsigned RW = DW + 1;
  // Selects the approximated low field of a 9-bit value (all zeros when exact).
  localparam logic [RW-1:0] LOW_MASK = RW'((RW'(1) << APPROX_BITS) - RW'(1));

  logic          s1_valid_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic          s2_valid_q;
  logic [RW-1:0] out_d_q;

  logic          s1_adv;

  logic [RW-1:0] hi_a_c;
  logic [RW-1:0] hi_b_c;
  logic [RW-1:0] hi_diff_c;
  logic [RW-1:0] res_c;

  // S1 may hand over when S2 is empty or S2 is being drained this cycle.
  assign s1_adv   = !s2_valid_q | out_ready;
  assign in_ready = !s1_valid_q | s1_adv;

  // Approximate difference: exact upper field, A's low field, no borrow between them.
  always_comb begin
    hi_a_c    = {1'b0, a_q} >> APPROX_BITS;
    hi_b_c    = {1'b0, b_q} >> APPROX_BITS;
    hi_diff_c = hi_a_c - hi_b_c;
    res_c     = (hi_diff_c << APPROX_BITS) | ({1'b0, a_q} & LOW_MASK);
  end

  // Stage 1: operand registers, refilled whenever the stage can accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        a_q <= in_a;
        b_q <= in_b;
      end
    end
  end

  // Stage 2: result register, held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      out_d_q    <= '0;
    end else if (s1_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_d_q <= res_c;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_d     = out_d_q;

`ifdef APPROX_ERRMON_EN
  localparam int unsigned SUM_XW = SUM_W + 1;

  logic              xfer;
  logic [RW-1:0]     err_c;
  logic [RW-1:0]     err_q;
  logic [RW-1:0]     err_max_q;
  logic [SUM_W-1:0]  err_sum_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [SUM_XW-1:0] sum_ext_c;

  assign xfer = s2_valid_q & out_ready;

  // Error of an approximate result is exactly B's dropped low field.
  assign err_c     = {1'b0, b_q} & LOW_MASK;
  assign sum_ext_c = {1'b0, err_sum_q} + SUM_XW'(err_q);

  // Error travels alongside the result so it is known at the output transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (s1_adv && s1_valid_q) begin
      err_q <= err_c;
    end
  end

  // Statistics: clear has priority over a coincident transfer; both accumulators saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_max_q <= '0;
      err_sum_q <= '0;
      err_cnt_q <= '0;
    end else if (stat_clr) begin
      err_max_q <= '0;
      err_sum_q <= '0;
      err_cnt_q <= '0;
    end else if (xfer) begin
      if (err_q > err_max_q) begin
        err_max_q <= err_q;
      end
      err_sum_q <= sum_ext_c[SUM_W] ? '1 : sum_ext_c[SUM_W-1:0];
      if (err_cnt_q != '1) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end

  assign err_max = err_max_q;
  assign err_sum = err_sum_q;
  assign err_cnt = err_cnt_q;
`else
  // Monitor not built: statistics read as zero, inputs only needed by it are sunk.
  logic unused_sink;
  assign unused_sink = ^{stat_clr, b_q};

  assign err_max = '0;
  assign err_sum = '0;
  assign err_cnt = '0;
`endif

endmodule
